qar_can_tx: RTL and testbench
=============================

# qar_can_tx

Bit-level CAN 2.0A frame transmitter for the QAR CAN peripheral. Given an 11-bit identifier, RTR flag, DLC and up to 8 data bytes, it serialises a standard data or remote frame onto `can_tx`. It handles bit stuffing and CRC-15, monitors `can_rx` for arbitration loss, bit errors and the ACK slot, and reports the outcome with one-cycle status pulses. It sits between the register-mapped CAN controller and the external transceiver.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; informational only, timing comes from `bittime`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  transmit request; accepted only in a cycle where `ready`=1.
- `ready`  out  1  idle and able to accept `start`.
- `frame_id`  in  11  identifier, sent MSB first.
- `frame_rtr`  in  1  RTR bit; 1 sends no data field.
- `frame_dlc`  in  4  DLC, sent verbatim.
- `frame_data`  in  64  payload; byte0 = [7:0], sent first, each byte MSB first.
- `bittime`  in  16  bit period is `bittime`+1 clk cycles; values <2 are treated as 2.
- `can_tx`  out  1  bus drive; 1 = recessive.
- `can_rx`  in  1  bus sense.
- `done`  out  1  one-cycle pulse: frame completed and acknowledged.
- `arb_lost`  out  1  one-cycle pulse: arbitration lost.
- `tx_err`  out  1  one-cycle pulse: bit error or missing ACK.

## Operation
- On `start` with `ready`=1, latch `frame_*` and `bittime`. Inputs are don't-care afterwards. `start` with `ready`=0 is ignored.
- Raw field order:
  - SOF(0), ID[10:0], RTR, IDE(0), r0(0), DLC[3:0].
  - Data: N = 0 if RTR, else min(DLC,8) bytes. DLC 9..15 sends 8 bytes.
  - CRC[14:0].
  - CRC delim(1), ACK slot(1), ACK delim(1), EOF 7×1, IFS 3×1.
- CRC-15:
  - Polynomial 0x4599, initial value 0.
  - Computed over raw (unstuffed) bits from SOF through the last data bit.
  - Per bit: `nxt = bit ^ crc[14]`; `crc = {crc[13:0],0}`; if `nxt`, `crc ^= 0x4599`.
- Stuffing:
  - Applies from SOF through CRC[0].
  - After 5 consecutive equal transmitted bits, insert one complement bit.
  - The stuff bit starts a new run of length 1.
  - Stuff bits are not CRC inputs.
  - No stuffing from CRC delim onward.
- FSM states: IDLE → ARB (SOF, ID, RTR) → CTRL (IDE, r0, DLC) → DATA (skipped if N=0) → CRC → TRAIL (delims, ACK, EOF, IFS) → IDLE.
- Monitoring: compare `can_rx` with the driven bit at each sample point.
  - ARB field (ID and RTR only): driven 1, sampled 0 → `arb_lost` and abort.
  - SOF, CTRL, DATA, CRC, CRC delim, ACK delim, EOF: mismatch → `tx_err` and abort. Stuff bits are included.
  - ACK slot: sampled 1 → `tx_err` and abort.
  - IFS: not checked.
- Abort: `can_tx`=1, return to IDLE, no retry, no error frame. The host retries.
- Reset mid-frame: `can_tx` goes to 1 asynchronously; all state returns to IDLE.

## Timing
- Reset values: `can_tx`=1, `ready`=1, `done`=0, `arb_lost`=0, `tx_err`=0.
- `ready` falls in the cycle after `start` is accepted.
- SOF is driven from that same cycle.
- Each bit, including stuff bits, holds for `bittime`+1 cycles.
- Bit counter runs 0..`bittime`. The new bit drives at count 0. `can_rx` is sampled at count = `bittime`>>1.
- Error pulses and abort occur in the cycle after the sample point. `can_tx`=1 and `ready`=1 in that same cycle.
- `done` pulses in the cycle after the last IFS bit period ends. `ready` rises in the same cycle.
- Frame length is 47 + 8·N + S bits, where S = number of stuff bits.
- At most one status pulse per frame. `start` in the same cycle as `done` or an error pulse is accepted, since `ready`=1.

## Test plan
- **ID=0x123, RTR=0, DLC=1, data 0xA5, bittime=9; bench loops `can_tx` to `can_rx` and forces ACK slot to 0.**
  - Destuffed stream matches the reference model, including CRC.
  - Each bit lasts 10 cycles.
  - Exactly one `done` pulse; no `arb_lost` or `tx_err`.
- **ID=0x000, RTR=0, DLC=0, loopback with ACK.**
  - A 1 stuff bit follows every run of 5 zeros; first at raw bit 5 (after SOF+ID[10:7]).
  - Total bits = 47 + S per the model; `done` pulses.
- **ID=0x7FF; bench forces `can_rx`=0 during ID[10].**
  - `arb_lost` pulses 1 cycle after that sample point.
  - `can_tx`=1 from then on; `ready`=1; no `done`.
- **Loopback but ACK slot left recessive.**
  - `tx_err` pulses after the ACK sample; `ready`=1; no `done`.
- **Bench flips `can_rx` during DLC[2].**
  - `tx_err` pulses, transmission aborts with `can_tx`=1.
- **Assert `rst` mid-DATA; also pulse `start` while busy.**
  - Reset: `can_tx`=1 immediately, `ready`=1, no pulses.
  - Busy `start`: ignored; latched frame unchanged.
  - DLC=12 case: exactly 8 data bytes sent.

Source files
------------

// File: rtl/qar_can_tx_if.sv
// Host/bus signal bundle for the CAN 2.0A frame transmitter.
// The host side drives frame requests and the sensed bus level; the transmitter drives the bus and status.
interface qar_can_tx_if;
  logic        start;
  logic        ready;
  logic [10:0] frame_id;
  logic        frame_rtr;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic [15:0] bittime;
  logic        can_tx;
  logic        can_rx;
  logic        done;
  logic        arb_lost;
  logic        tx_err;

  modport master (
    output start, frame_id, frame_rtr, frame_dlc, frame_data, bittime, can_rx,
    input  ready, can_tx, done, arb_lost, tx_err
  );

  modport slave (
    input  start, frame_id, frame_rtr, frame_dlc, frame_data, bittime, can_rx,
    output ready, can_tx, done, arb_lost, tx_err
  );
endinterface

// File: rtl/qar_can_tx.sv
// CAN 2.0A standard data/remote frame serialiser with bit stuffing, CRC-15,
// arbitration/bit-error/ACK monitoring and one-cycle outcome pulses.
module qar_can_tx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  qar_can_tx_if.slave    bus
);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_TRAIL} state_t;

  state_t      r_state, w_state_nxt, w_succ_state;
  logic [15:0] r_bt, r_cnt;
  logic [5:0]  r_idx, w_succ_idx;
  logic [10:0] r_id;
  logic        r_rtr;
  logic [3:0]  r_dlc, r_nbytes;
  logic [63:0] r_data;
  logic [14:0] r_crc, w_crc_upd;
  logic        r_can_tx, r_run_bit;
  logic [2:0]  r_run_len;
  logic        r_done, r_arb_lost, r_tx_err;
  logic        w_start, w_bit_end, w_sample, w_stuff_now, w_last_data;
  logic        w_raw, w_mis, w_arb, w_err, w_abort, w_crc_in;
  logic [3:0]  w_id_sel;
  logic [2:0]  w_dlc_sel;

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.can_tx   = r_can_tx;
  assign bus.done     = r_done;
  assign bus.arb_lost = r_arb_lost;
  assign bus.tx_err   = r_tx_err;

  assign w_start     = bus.start && (r_state == S_IDLE);
  assign w_bit_end   = (r_cnt == r_bt);
  assign w_sample    = (r_cnt == {1'b0, r_bt[15:1]});
  assign w_last_data = (r_idx == {r_nbytes[2:0] - 3'd1, 3'b111});
  // Five equal bits already on the wire inside the stuffed region force a complement bit next.
  assign w_stuff_now = (r_run_len == 3'd5) &&
                       (r_state inside {S_ARB, S_CTRL, S_DATA, S_CRC});
  assign w_id_sel    = 4'd11 - w_succ_idx[3:0];
  assign w_dlc_sel   = 3'd5 - w_succ_idx[2:0];
  assign w_crc_in    = w_raw ^ r_crc[14];
  assign w_crc_upd   = {r_crc[13:0], 1'b0} ^ (w_crc_in ? 15'h4599 : 15'h0000);

  // Raw-bit successor of the current position; stuff bits keep the index of the bit they follow.
  always_comb begin
    w_succ_state = r_state;
    w_succ_idx   = r_idx + 6'd1;
    case (r_state)
      S_ARB:   if (r_idx == 6'd12) begin w_succ_state = S_CTRL; w_succ_idx = '0; end
      S_CTRL:  if (r_idx == 6'd5) begin
                 w_succ_state = (r_nbytes == 4'd0) ? S_CRC : S_DATA;
                 w_succ_idx   = '0;
               end
      S_DATA:  if (w_last_data) begin w_succ_state = S_CRC; w_succ_idx = '0; end
      S_CRC:   if (r_idx == 6'd14) begin w_succ_state = S_TRAIL; w_succ_idx = '0; end
      S_TRAIL: if (r_idx == 6'd12) begin w_succ_state = S_IDLE; w_succ_idx = '0; end
      default: ;
    endcase
  end

  always_comb begin
    w_raw = 1'b1;
    case (w_succ_state)
      S_ARB:   w_raw = (w_succ_idx == 6'd12) ? r_rtr : r_id[w_id_sel];
      S_CTRL:  w_raw = (w_succ_idx < 6'd2) ? 1'b0 : r_dlc[w_dlc_sel[1:0]];
      S_DATA:  w_raw = r_data[{w_succ_idx[5:3], ~w_succ_idx[2:0]}];
      S_CRC:   w_raw = r_crc[14];
      default: w_raw = 1'b1;
    endcase
  end

  // Bus monitor at the sample point: recessive overwritten in ID/RTR is lost arbitration.
  always_comb begin
    w_mis = (bus.can_rx != r_can_tx);
    w_arb = 1'b0;
    w_err = 1'b0;
    case (r_state)
      S_ARB: begin
        if (r_idx == 6'd0) w_err = w_mis;
        else begin
          w_arb = w_mis &  r_can_tx;
          w_err = w_mis & ~r_can_tx;
        end
      end
      S_CTRL, S_DATA, S_CRC: w_err = w_mis;
      S_TRAIL: begin
        if (r_idx == 6'd1)      w_err = bus.can_rx;
        else if (r_idx < 6'd10) w_err = w_mis;
      end
      default: ;
    endcase
    w_arb   = w_arb & w_sample;
    w_err   = w_err & w_sample;
    w_abort = w_arb | w_err;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_ARB;
      default: begin
        if (w_abort)                       w_state_nxt = S_IDLE;
        else if (w_bit_end && !w_stuff_now) w_state_nxt = w_succ_state;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bt       <= 16'd2;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_id       <= '0;
      r_rtr      <= 1'b0;
      r_dlc      <= '0;
      r_nbytes   <= '0;
      r_data     <= '0;
      r_crc      <= '0;
      r_can_tx   <= 1'b1;
      r_run_bit  <= 1'b1;
      r_run_len  <= 3'd1;
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      r_tx_err   <= 1'b0;
      if (w_start) begin
        r_id      <= bus.frame_id;
        r_rtr     <= bus.frame_rtr;
        r_dlc     <= bus.frame_dlc;
        r_data    <= bus.frame_data;
        r_nbytes  <= bus.frame_rtr ? 4'd0 : (bus.frame_dlc[3] ? 4'd8 : bus.frame_dlc);
        r_bt      <= (bus.bittime < 16'd2) ? 16'd2 : bus.bittime;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_crc     <= '0;  // SOF (0) into a zero CRC leaves it zero
        r_can_tx  <= 1'b0;
        r_run_bit <= 1'b0;
        r_run_len <= 3'd1;
      end else if (r_state != S_IDLE) begin
        if (w_abort) begin
          r_can_tx   <= 1'b1;
          r_arb_lost <= w_arb;
          r_tx_err   <= w_err;
        end else if (w_bit_end) begin
          r_cnt <= '0;
          if (w_stuff_now) begin
            r_can_tx  <= ~r_run_bit;
            r_run_bit <= ~r_run_bit;
            r_run_len <= 3'd1;
          end else if (w_succ_state == S_IDLE) begin
            r_can_tx <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_idx     <= w_succ_idx;
            r_can_tx  <= w_raw;
            r_run_bit <= w_raw;
            r_run_len <= (w_raw == r_run_bit) ? r_run_len + 3'd1 : 3'd1;
            if (w_succ_state inside {S_ARB, S_CTRL, S_DATA}) r_crc <= w_crc_upd;
            else if (w_succ_state == S_CRC)                  r_crc <= {r_crc[13:0], 1'b0};
          end
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_qar_can_tx.sv
// Directed bench for qar_can_tx: a frame model fills a bit scoreboard that is drained as the DUT transmits.
module tb_qar_can_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovr_en = 1'b0;
  logic ovr_val = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_q[$];
  logic obs_q[$];

  qar_can_tx_if bus();
  qar_can_tx #(.CLK_HZ(50_000_000)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  // Bus loopback with per-bit override used for ACK, arbitration and error injection.
  assign bus.can_rx = ovr_en ? ovr_val : bus.can_tx;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk({tag, "_idle_flags"}, {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx}, 5'b10001);
      @(negedge clk);
    end
  endtask

  // fkind: 0 none, 1 force dominant (arb loss), 2 flip bit (bit error), 3 ACK left recessive
  task automatic run_frame(input string nm, input logic [10:0] id, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data, input logic [15:0] bt,
                           input int fkind, input int fraw, input int busy_k, input int rst_at_raw);
    logic raw [0:127];
    int   pos [0:127];
    int   nr, nd, nb, ack_pos, fk, rk, bte, half, len, run;
    logic [14:0] crc;
    logic nx, last, e;

    nr = 0;
    raw[nr] = 1'b0; nr++;
    for (int i = 10; i >= 0; i--) begin raw[nr] = id[i]; nr++; end
    raw[nr] = rtr; nr++;
    raw[nr] = 1'b0; nr++;
    raw[nr] = 1'b0; nr++;
    for (int i = 3; i >= 0; i--) begin raw[nr] = dlc[i]; nr++; end
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int b = 0; b < nb; b++)
      for (int i = 7; i >= 0; i--) begin raw[nr] = data[8*b + i]; nr++; end
    nd = nr;
    crc = '0;
    for (int j = 0; j < nd; j++) begin
      nx  = raw[j] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nx) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) begin raw[nr] = crc[i]; nr++; end

    exp_q.delete();
    obs_q.delete();
    last = 1'b0;
    run  = 0;
    for (int j = 0; j < nr; j++) begin
      pos[j] = exp_q.size();
      exp_q.push_back(raw[j]);
      if (j > 0 && raw[j] == last) run++;
      else run = 1;
      last = raw[j];
      if (run == 5) begin
        exp_q.push_back(~raw[j]);
        last = ~raw[j];
        run  = 1;
      end
    end
    exp_q.push_back(1'b1);
    ack_pos = exp_q.size();
    for (int i = 0; i < 12; i++) exp_q.push_back(1'b1);
    len  = exp_q.size();
    bte  = (bt < 16'd2) ? 2 : int'(bt);
    half = bte / 2;
    fk   = (fkind == 3) ? ack_pos : ((fkind > 0) ? pos[fraw] : -1);
    rk   = (rst_at_raw >= 0) ? pos[rst_at_raw] : -1;

    bus.frame_id   = id;
    bus.frame_rtr  = rtr;
    bus.frame_dlc  = dlc;
    bus.frame_data = data;
    bus.bittime    = bt;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    for (int k = 0; k < len; k++) begin
      e       = exp_q.pop_front();
      ovr_en  = (k == fk) || (k == ack_pos);
      ovr_val = (k == fk) ? ((fkind == 2) ? ~e : (fkind == 3)) : 1'b0;
      for (int c = 0; c <= bte; c++) begin
        if (k == 0 && c == 0) begin
          bus.frame_id   = 11'($urandom);
          bus.frame_rtr  = 1'($urandom);
          bus.frame_dlc  = 4'($urandom);
          bus.frame_data = {$urandom, $urandom};
          bus.bittime    = 16'($urandom_range(0, 20));
        end
        if (k == busy_k) bus.start = (c == 0);
        if (k == rk && c == 1) begin
          rst = 1'b1;
          #1;
          chk({nm, "_rst_flags"}, {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx}, 5'b10001);
          @(negedge clk);
          rst    = 1'b0;
          ovr_en = 1'b0;
          idle_check(nm, 3 * (bte + 1));
          return;
        end
        if (k == fk && c == half + 1) begin
          ovr_en = 1'b0;
          chk({nm, "_abort_flags"}, {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx},
              (fkind == 1) ? 5'b10101 : 5'b10011);
          @(negedge clk);
          idle_check(nm, 3 * (bte + 1));
          return;
        end
        if (c == 0) obs_q.push_back(bus.can_tx);
        chk({nm, "_can_tx"}, bus.can_tx, e);
        chk({nm, "_busy_flags"}, {bus.ready, bus.done, bus.arb_lost, bus.tx_err}, 4'b0000);
        @(negedge clk);
      end
    end
    ovr_en = 1'b0;
    chk({nm, "_done_flags"}, {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx}, 5'b11001);
    @(negedge clk);
    chk({nm, "_after_done"}, {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx}, 5'b10001);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.frame_id   = '0;
    bus.frame_rtr  = 1'b0;
    bus.frame_dlc  = '0;
    bus.frame_data = '0;
    bus.bittime    = '0;
    repeat (3) @(negedge clk);
    chk("reset_held", {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx}, 5'b10001);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_released", {bus.ready, bus.done, bus.arb_lost, bus.tx_err, bus.can_tx}, 5'b10001);

    run_frame("t1_basic", 11'h123, 1'b0, 4'd1, 64'h00000000_000000A5, 16'd9, 0, 0, -1, -1);

    run_frame("t2_zeros", 11'h000, 1'b0, 4'd0, 64'h0, 16'd0, 0, 0, -1, -1);
    chk("t2_first_stuff", obs_q[5], 1'b1);
    chk("t2_pre_stuff", obs_q[4], 1'b0);

    run_frame("t3_arb", 11'h7FF, 1'b0, 4'd2, 64'h0000_0000_0000_BEEF, 16'd5, 1, 1, -1, -1);

    run_frame("t4_noack", 11'h055, 1'b0, 4'd2, 64'h0000_0000_0000_3C5A, 16'd4, 3, 0, -1, -1);

    run_frame("t5_biterr", 11'h321, 1'b0, 4'd3, 64'h0000_0000_0012_3456, 16'd3, 2, 16, -1, -1);

    run_frame("t6_dlc12", 11'h2AA, 1'b0, 4'd12, 64'hF00D_CAFE_0000_FFFF, 16'd2, 0, 0, 30, -1);

    run_frame("t7_rst", 11'h1C3, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 16'd3, 0, 0, -1, 29);

    run_frame("t8_rtr", 11'h4F1, 1'b1, 4'd5, 64'hDEAD_BEEF_DEAD_BEEF, 16'd2, 0, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
